// File: rtl/seg_display_engine.sv
// seg_display_engine: multi-digit 7-segment driver with sequential shift-add-3 BCD
// conversion, signed/unsigned/hex formatting and registered scan multiplexing.
module seg_display_engine #(
  parameter int WIDTH          = 8,
  parameter int DIGITS         = 4,
  parameter int SCAN_BITS      = 16,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic [1:0]        mode,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ready
);
  localparam int NBCD = (WIDTH * 301) / 1000 + 1;
  localparam int NNIB = (WIDTH + 3) / 4;
  localparam int MX0  = NBCD > DIGITS ? NBCD : DIGITS;
  localparam int MX   = MX0 > NNIB ? MX0 : NNIB;
  localparam int IW   = $clog2(DIGITS);
  localparam int CW   = $clog2(WIDTH);
  localparam logic [6:0] DASH = 7'h40;
  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;
  state_t                   state_q, state_d;
  logic                     snap_v_q, neg_q, ready_q, change, capture, neg, hex_ovf, dec_ovf;
  logic [WIDTH-1:0]         val_q, sr_q, mag;
  logic [1:0]               mode_q;
  logic [4*NBCD-1:0]        bcd_q, adj, bcd_step;
  logic [4*MX-1:0]          bcd_pad, hexv;
  logic [CW-1:0]            cnt_q;
  logic [DIGITS-1:0][6:0]   dig_q, dig_d, fmt;
  logic [SCAN_BITS-1:0]     scan_q;
  logic [IW-1:0]            idx_q, idx_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [6:0]               seg_q, seg_d;
  int                       msd;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F; 4'h1: glyph = 7'h06; 4'h2: glyph = 7'h5B; 4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66; 4'h5: glyph = 7'h6D; 4'h6: glyph = 7'h7D; 4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F; 4'h9: glyph = 7'h6F; 4'hA: glyph = 7'h77; 4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39; 4'hD: glyph = 7'h5E; 4'hE: glyph = 7'h79; default: glyph = 7'h71;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    change  = !snap_v_q || {value, mode} != {val_q, mode_q};
    capture = state_q == IDLE && change;
    state_d = state_q == IDLE ? (change ? CONV : IDLE) :
              state_q == CONV ? (cnt_q == CW'(WIDTH - 1) ? UPDATE : CONV) : IDLE;
  end

  always_comb busy = state_q != IDLE;

  always_comb begin
    neg = mode == 2'd0 && value[WIDTH-1];
    mag = neg ? WIDTH'(-{value[WIDTH-1], value}) : value;
    for (int k = 0; k < NBCD; k++)
      adj[4*k+:4] = bcd_q[4*k+:4] >= 4'd5 ? bcd_q[4*k+:4] + 4'd3 : bcd_q[4*k+:4];
    bcd_step = (4*NBCD)'({adj, sr_q[WIDTH-1]});
  end

  // Decimal digits above the most significant non-zero one are blank, except the sign slot.
  always_comb begin
    bcd_pad = '0;
    bcd_pad[4*NBCD-1:0] = bcd_q;
    hexv = '0;
    hexv[WIDTH-1:0] = val_q;
    msd = 0;
    hex_ovf = 1'b0;
    fmt = '0;
    for (int k = 0; k < MX; k++) begin
      if (bcd_pad[4*k+:4] != 4'd0) msd = k;
      if (k >= DIGITS && hexv[4*k+:4] != 4'd0) hex_ovf = 1'b1;
    end
    dec_ovf = msd + 1 + int'(neg_q) > DIGITS;
    for (int i = 0; i < DIGITS; i++)
      fmt[i] = mode_q == 2'd3 ? 7'h00 :
               mode_q == 2'd2 ? (hex_ovf ? DASH : glyph(hexv[4*i+:4])) :
               dec_ovf ? DASH : i <= msd ? glyph(bcd_pad[4*i+:4]) :
               (neg_q && i == msd + 1) ? DASH : 7'h00;
  end

  // Segments follow the next digit contents so anode and pattern switch together.
  always_comb begin
    dig_d = state_q == UPDATE ? fmt : dig_q;
    idx_d = &scan_q ? (idx_q == IW'(DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    an_d  = ~(DIGITS'(1) << idx_d);
    seg_d = SEG_ACTIVE_LOW != 0 ? ~dig_d[idx_d] : dig_d[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      snap_v_q <= 1'b0;
      val_q    <= '0;
      mode_q   <= '0;
      neg_q    <= 1'b0;
      sr_q     <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      dig_q    <= '0;
      ready_q  <= 1'b0;
      scan_q   <= '0;
      idx_q    <= '0;
      an_q     <= ~DIGITS'(1);
      seg_q    <= SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;
    end else begin
      if (capture) begin
        snap_v_q <= 1'b1;
        val_q    <= value;
        mode_q   <= mode;
        neg_q    <= neg;
        sr_q     <= mag;
        bcd_q    <= '0;
        cnt_q    <= '0;
      end else if (state_q == CONV) begin
        sr_q  <= sr_q << 1;
        bcd_q <= bcd_step;
        cnt_q <= cnt_q + 1'b1;
      end
      dig_q   <= dig_d;
      ready_q <= state_q == UPDATE;
      scan_q  <= scan_q + 1'b1;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end

  assign seg   = seg_q;
  assign an    = an_q;
  assign ready = ready_q;
endmodule

// File: tb/tb_seg_display_engine.sv
// tb_seg_display_engine: directed checks of formatting, latency, re-conversion, reset and scanning
// on three configurations: 8b/4 digits, 16b/4 digits, 16b/3 digits active-high segments.
module tb_seg_display_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  v8 = '0;
  logic [15:0] v16a = '0, v16b = '0;
  logic [1:0]  m8 = '0, m16a = '0, m16b = '0;
  logic [6:0]  seg0, seg1, seg2;
  logic [3:0]  an0, an1;
  logic [2:0]  an2, bsy, rdy;
  logic [6:0]  sh0 [4], sh1 [4], sh2 [3];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  seg_display_engine #(.WIDTH(8), .DIGITS(4), .SCAN_BITS(2), .SEG_ACTIVE_LOW(1)) u0 (
    .clk(clk), .rst_n(rst_n), .value(v8), .mode(m8), .seg(seg0), .an(an0), .busy(bsy[0]), .ready(rdy[0]));
  seg_display_engine #(.WIDTH(16), .DIGITS(4), .SCAN_BITS(2), .SEG_ACTIVE_LOW(1)) u1 (
    .clk(clk), .rst_n(rst_n), .value(v16a), .mode(m16a), .seg(seg1), .an(an1), .busy(bsy[1]), .ready(rdy[1]));
  seg_display_engine #(.WIDTH(16), .DIGITS(3), .SCAN_BITS(2), .SEG_ACTIVE_LOW(0)) u2 (
    .clk(clk), .rst_n(rst_n), .value(v16b), .mode(m16b), .seg(seg2), .an(an2), .busy(bsy[2]), .ready(rdy[2]));

  // Latch the lit pattern of whichever digit is currently driven.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!an0[i]) sh0[i] = ~seg0;
      if (!an1[i]) sh1[i] = ~seg1;
    end
    for (int i = 0; i < 3; i++) if (!an2[i]) sh2[i] = seg2;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [6:0] glyph(input logic [7:0] c);
    case (c)
      "0": glyph = 7'h3F; "1": glyph = 7'h06; "2": glyph = 7'h5B; "3": glyph = 7'h4F;
      "4": glyph = 7'h66; "5": glyph = 7'h6D; "6": glyph = 7'h7D; "7": glyph = 7'h07;
      "8": glyph = 7'h7F; "9": glyph = 7'h6F; "A": glyph = 7'h77; "B": glyph = 7'h7C;
      "C": glyph = 7'h39; "D": glyph = 7'h5E; "E": glyph = 7'h79; "F": glyph = 7'h71;
      "-": glyph = 7'h40; default: glyph = 7'h00;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input int d, input logic [15:0] v, input logic [1:0] m);
    case (d)
      0: begin v8 = v[7:0]; m8 = m; end
      1: begin v16a = v; m16a = m; end
      default: begin v16b = v; m16b = m; end
    endcase
  endtask

  task automatic wait_ready(input int d, input int lim, output int n, output int nb, output bit ok);
    n = 0; nb = 0; ok = 1'b0;
    while (n < lim && !ok) begin
      tick();
      n++;
      nb += int'(bsy[d]);
      ok = rdy[d];
    end
  endtask

  task automatic wait_busy(input int d);
    int n = 0;
    while (n < 5 && !bsy[d]) begin tick(); n++; end
    chk($sformatf("busy start dut%0d", d), 32'(bsy[d]), 1);
  endtask

  task automatic chk_disp(input int d, input logic [31:0] exp, input string tag);
    logic [6:0] act;
    for (int i = 0; i < (d == 2 ? 3 : 4); i++) begin
      case (d)
        0: act = sh0[i];
        1: act = sh1[i];
        default: act = sh2[i];
      endcase
      chk($sformatf("%s dig%0d", tag, i), 32'(act), 32'(glyph(exp[8*i+:8])));
    end
  endtask

  typedef struct {
    int          d;
    logic [15:0] v;
    logic [1:0]  m;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t vt [16];
    int n, nb, pulses;
    bit ok, first;
    logic [6:0] snap [3];
    logic [2:0] prev;
    logic [31:0] scan_exp;
    int run, ai;
    vt[0]  = '{0, 16'h0080, 2'd0, "-128"};
    vt[1]  = '{0, 16'h00FF, 2'd1, " 255"};
    vt[2]  = '{0, 16'h00FF, 2'd2, "00FF"};
    vt[3]  = '{0, 16'h0000, 2'd0, "   0"};
    vt[4]  = '{0, 16'h007F, 2'd0, " 127"};
    vt[5]  = '{0, 16'h0005, 2'd3, "    "};
    vt[6]  = '{1, 16'd12345, 2'd1, "----"};
    vt[7]  = '{1, 16'hFC19, 2'd0, "-999"};
    vt[8]  = '{1, 16'hFC18, 2'd0, "----"};
    vt[9]  = '{1, 16'h8000, 2'd0, "----"};
    vt[10] = '{1, 16'd9999, 2'd1, "9999"};
    vt[11] = '{1, 16'h00FF, 2'd2, "00FF"};
    vt[12] = '{2, 16'h1234, 2'd2, "---"};
    vt[13] = '{2, 16'hFF9D, 2'd0, "-99"};
    vt[14] = '{2, 16'hFF9C, 2'd0, "---"};
    vt[15] = '{2, 16'h0ABC, 2'd2, "ABC"};

    repeat (2) tick();
    chk("reset busy", 32'(bsy), 0);
    chk("reset ready", 32'(rdy), 0);
    chk("reset seg0", 32'(seg0), 32'h7F);
    chk("reset an0", 32'(an0), 32'b1110);
    chk("reset seg2", 32'(seg2), 0);
    chk("reset an2", 32'(an2), 32'b110);
    rst_n = 1'b1;
    repeat (30) tick();

    apply(0, 16'h0085, 2'd0);
    wait_ready(0, 20, n, nb, ok);
    chk("lat ready seen", 32'(ok), 1);
    chk("lat edges", n, 10);
    chk("lat busy cycles", nb, 9);
    repeat (20) tick();
    chk_disp(0, "-123", "h85 signed");

    for (int k = 0; k < 16; k++) begin
      apply(vt[k].d, vt[k].v, vt[k].m);
      wait_ready(vt[k].d, 40, n, nb, ok);
      chk($sformatf("vec%0d ready", k), 32'(ok), 1);
      repeat (20) tick();
      chk_disp(vt[k].d, vt[k].exp, $sformatf("vec%0d", k));
    end

    apply(2, 16'd7, 2'd0);
    wait_busy(2);
    repeat (3) tick();
    v16b = 16'd42;
    pulses = 0;
    for (int t = 0; t < 120 && pulses < 2; t++) begin
      tick();
      if (rdy[2]) pulses++;
      else if (pulses == 1) snap = sh2;
    end
    chk("reconv second ready", pulses, 2);
    for (int i = 0; i < 3; i++) chk($sformatf("first show dig%0d", i), 32'(snap[i]), i == 0 ? 32'(glyph("7")) : 0);
    for (int t = 0; t < 30; t++) begin tick(); if (rdy[2]) pulses++; end
    chk("reconv total ready", pulses, 2);
    chk_disp(2, " 42", "reconv");

    apply(0, 16'd99, 2'd0);
    wait_busy(0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", 32'(bsy), 0);
    chk("midrst ready", 32'(rdy), 0);
    chk("midrst seg0", 32'(seg0), 32'h7F);
    chk("midrst an0", 32'(an0), 32'b1110);
    chk("midrst seg2", 32'(seg2), 0);
    apply(2, 16'h0ABC, 2'd2);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_ready(0, 10, n, nb, ok);
    chk("post rst ready", 32'(ok), 1);
    repeat (20) tick();
    chk_disp(0, "  99", "post rst");
    chk_disp(2, " ABC", "post rst d3");

    scan_exp = " ABC";
    prev = an2;
    run = 1;
    first = 1'b1;
    for (int t = 0; t < 48; t++) begin
      tick();
      if (an2 != prev) begin
        if (!first) chk("scan hold", run, 4);
        chk("scan order", 32'(an2), 32'({prev[1:0], prev[2]}));
        first = 1'b0;
        run = 1;
        prev = an2;
      end else run++;
      ai = an2 == 3'b110 ? 0 : an2 == 3'b101 ? 1 : an2 == 3'b011 ? 2 : 3;
      chk("scan seg", 32'(seg2), ai < 3 ? 32'(glyph(scan_exp[8*ai+:8])) : 32'h80);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
